// File: rtl/frame_uart_pkg.sv
// Shared types and width helpers for the framed-JPEG UART transmitter.
// Widths are derived from the module parameters through the helper functions.
package frame_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_e;

    localparam int DEF_CLOCK_DIVIDER = 6;
    localparam int DEF_FIFO_DEPTH    = 512;
    localparam int DROP_COUNT_MAX    = 255;
    localparam int DATA_BITS         = 8;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    // One extra bit so a full FIFO (count == depth) is representable.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int baud_w(input int div);
        return $clog2(div);
    endfunction

endpackage

// File: rtl/frame_uart_tx_byte_fifo.sv
// Single-clock byte FIFO with a registered read port so the array maps to BRAM/SPRAM.
// The memory itself carries no reset; only pointers and the occupancy count do.
module byte_fifo
    import frame_uart_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                    clock,
    input  logic                    nreset,
    input  logic                    wr_en_i,
    input  logic [7:0]              wr_data_i,
    input  logic                    rd_en_i,
    output logic [7:0]              rd_data_o,
    output logic [cnt_w(DEPTH)-1:0] count_o,
    output logic                    full_o,
    output logic                    empty_o
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam int CNT_W = cnt_w(DEPTH);

    logic [7:0]       mem_q [DEPTH];
    logic [7:0]       rd_data_q;
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_wr, do_rd;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);

    // Full is judged on the start-of-cycle count, so a same-cycle read never
    // makes room for a write.
    assign do_wr = wr_en_i && !full_o;
    assign do_rd = rd_en_i && !empty_o;

    always_ff @(posedge clock) begin
        if (do_wr) mem_q[wptr_q] <= wr_data_i;
        if (do_rd) rd_data_q <= mem_q[rptr_q];
    end

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_wr) wptr_d = wptr_q + PTR_W'(1);
        if (do_rd) rptr_d = rptr_q + PTR_W'(1);
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    assign rd_data_o = rd_data_q;
    assign count_o   = count_q;

endmodule

// File: rtl/frame_uart_tx.sv
// Buffers the stuffer's framed byte stream and serialises it as 8N1 UART.
// Bytes arriving while the FIFO is full are dropped and counted per frame.
module frame_uart_tx
    import frame_uart_pkg::*;
#(
    parameter int CLOCK_DIVIDER = DEF_CLOCK_DIVIDER,
    parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH
) (
    input  logic       clock,
    input  logic       nreset,
    input  logic [7:0] data_in,
    input  logic       data_in_valid,
    input  logic       vsync_in,
    output logic       uart_tx,
    output logic       idle,
    output logic       overflow,
    output logic [7:0] drop_count
);

    localparam int CNT_W  = cnt_w(FIFO_DEPTH);
    localparam int BAUD_W = baud_w(CLOCK_DIVIDER);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLOCK_DIVIDER - 1);
    localparam logic [2:0]        BIT_LAST  = 3'(DATA_BITS - 1);
    localparam logic [7:0]        DROP_MAX  = 8'(DROP_COUNT_MAX);

    tx_state_e         state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        sh_q, sh_d;
    logic              tx_q, tx_d;
    logic              idle_q, idle_d;
    logic              vs_q;
    logic              ovf_q, ovf_d;
    logic [7:0]        dcnt_q, dcnt_d;

    logic              fifo_rd;
    logic [7:0]        fifo_rd_data;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full, fifo_empty;
    logic              baud_end, vs_fall, drop, accept;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .nreset    (nreset),
        .wr_en_i   (data_in_valid),
        .wr_data_i (data_in),
        .rd_en_i   (fifo_rd),
        .rd_data_o (fifo_rd_data),
        .count_o   (fifo_count),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    assign baud_end = (baud_q == BAUD_LAST);
    assign accept   = data_in_valid && !fifo_full;
    assign drop     = data_in_valid && fifo_full;
    assign vs_fall  = vs_q && !vsync_in;

    // Baud counter restarts on every state entry, including each new data bit.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + BAUD_W'(1);
        bit_d   = bit_q;
        sh_d    = sh_q;
        fifo_rd = 1'b0;
        case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                if (!fifo_empty) begin
                    fifo_rd = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                baud_d  = '0;
                bit_d   = '0;
                sh_d    = fifo_rd_data;
                state_d = ST_START;
            end
            ST_START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == BIT_LAST) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        sh_d  = {1'b0, sh_q[7:1]};
                    end
                end
            end
            ST_STOP: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                baud_d  = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Line level is registered from next-state so uart_tx tracks the state glitch-free.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = sh_d[0];
            default:  tx_d = 1'b1;
        endcase
        idle_d = (state_d == ST_IDLE) && (fifo_count == '0) && !accept;
    end

    // A drop in the frame-boundary cycle belongs to the new frame.
    always_comb begin
        ovf_d  = ovf_q;
        dcnt_d = dcnt_q;
        if (drop) begin
            ovf_d = 1'b1;
            if (vs_fall)                 dcnt_d = 8'd1;
            else if (dcnt_q != DROP_MAX) dcnt_d = dcnt_q + 8'd1;
        end else if (vs_fall) begin
            ovf_d  = 1'b0;
            dcnt_d = '0;
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            tx_q    <= 1'b1;
            idle_q  <= 1'b1;
            vs_q    <= 1'b0;
            ovf_q   <= 1'b0;
            dcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            tx_q    <= tx_d;
            idle_q  <= idle_d;
            vs_q    <= vsync_in;
            ovf_q   <= ovf_d;
            dcnt_q  <= dcnt_d;
        end
    end

    assign uart_tx    = tx_q;
    assign idle       = idle_q;
    assign overflow   = ovf_q;
    assign drop_count = dcnt_q;

endmodule

// File: tb/tb_frame_uart_tx.sv
// Bench for frame_uart_tx: cycle-level occupancy/flag model plus a UART-decoding
// monitor that pops expected bytes from a scoreboard queue.
module tb_frame_uart_tx;

    localparam int DIV   = 6;
    localparam int DEPTH = 16;
    localparam int SLOT  = 10 * DIV + 2;

    logic       clock = 1'b0;
    logic       nreset = 1'b0;
    logic [7:0] data_in = '0;
    logic       data_in_valid = 1'b0;
    logic       vsync_in = 1'b0;
    logic       uart_tx, idle, overflow;
    logic [7:0] drop_count;

    always #5 clock = ~clock;

    frame_uart_tx #(
        .CLOCK_DIVIDER (DIV),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .clock         (clock),
        .nreset        (nreset),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .vsync_in      (vsync_in),
        .uart_tx       (uart_tx),
        .idle          (idle),
        .overflow      (overflow),
        .drop_count    (drop_count)
    );

    int         n_cmp = 0, n_fail = 0;
    bit         tx_hist[$];
    bit         id_hist[$];
    logic [7:0] mq[$];
    logic [7:0] exp_q[$];
    int         free_at = 0;
    bit         m_vsq = 0, m_ovf = 0;
    int         m_dcnt = 0;
    bit         vs_cur = 0;

    bit         m_act = 0, m_ok = 0;
    int         m_t = 0, p = 0, ph = 0;
    logic [7:0] m_byte = '0, e = '0;

    task automatic chk(input string nm, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, advance the reference model, check flags.
    // The model treats the transmitter as busy for SLOT cycles after each read.
    task automatic cyc(input bit v, input logic [7:0] d, input bit vs);
        int c, sz;
        bit rd, wr, drp, fall, m_idle;
        c = tx_hist.size();
        data_in_valid = v;
        data_in       = d;
        vsync_in      = vs;
        tx_hist.push_back(uart_tx);
        id_hist.push_back(idle);
        sz   = mq.size();
        rd   = (sz > 0) && (c >= free_at);
        wr   = v && (sz < DEPTH);
        drp  = v && !wr;
        fall = m_vsq && !vs;
        if (wr) begin
            mq.push_back(d);
            exp_q.push_back(d);
        end
        if (rd) begin
            void'(mq.pop_front());
            free_at = c + SLOT;
        end
        if (drp) begin
            m_ovf  = 1;
            m_dcnt = fall ? 1 : ((m_dcnt < 255) ? m_dcnt + 1 : 255);
        end else if (fall) begin
            m_ovf  = 0;
            m_dcnt = 0;
        end
        m_vsq  = vs;
        m_idle = (mq.size() == 0) && ((c + 1) >= free_at);
        @(posedge clock);
        #1;
        chk("flags{ovf,dcnt,idle}", int'({overflow, drop_count, idle}),
            int'({m_ovf, 8'(m_dcnt), m_idle}));
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (!(idle === 1'b1 && exp_q.size() == 0) && n < 4000) begin
            cyc(1'b0, 8'h00, 1'b0);
            n++;
        end
        chk({nm, "_drain_in_budget"}, int'(n < 4000), 1);
    endtask

    task automatic mid_reset();
        nreset        = 1'b0;
        data_in_valid = 1'b0;
        vsync_in      = 1'b0;
        #1;
        chk("rst_tx_async", int'(uart_tx), 1);
        chk("rst_idle_async", int'(idle), 1);
        repeat (3) @(posedge clock);
        #1;
        nreset = 1'b1;
        mq.delete();
        exp_q.delete();
        free_at = tx_hist.size();
        m_ovf   = 0;
        m_dcnt  = 0;
        m_vsq   = 0;
    endtask

    function automatic int find_fall(input int from, input int to);
        for (int i = (from < 1) ? 1 : from; i <= to && i < tx_hist.size(); i++)
            if (tx_hist[i-1] && !tx_hist[i]) return i;
        return -1;
    endfunction

    initial begin
        int t0, t1, f1, f2;
        bit ok;
        logic [7:0] a5;
        a5 = 8'hA5;

        fork
            forever begin
                @(negedge clock);
                if (!nreset) begin
                    m_act = 0;
                end else if (!m_act) begin
                    if (!uart_tx) begin
                        m_act  = 1;
                        m_t    = 0;
                        m_ok   = 1;
                        m_byte = '0;
                    end
                end else begin
                    m_t++;
                    p  = m_t / DIV;
                    ph = m_t % DIV;
                    if (p == 0) begin
                        if (uart_tx) m_ok = 0;
                    end else if (p <= 8) begin
                        if (ph == 0) m_byte[p-1] = uart_tx;
                        else if (m_byte[p-1] != uart_tx) m_ok = 0;
                    end else if (!uart_tx) begin
                        m_ok = 0;
                    end
                    if (m_t == 10 * DIV - 1) begin
                        m_act = 0;
                        if (exp_q.size() == 0) begin
                            n_cmp++;
                            n_fail++;
                            $display("FAIL char_unexpected: got 0x%0h expected none", m_byte);
                        end else begin
                            e = exp_q.pop_front();
                            chk("char{framing_ok,byte}", int'({m_ok, m_byte}), int'({1'b1, e}));
                        end
                    end
                end
            end
        join_none

        repeat (3) @(posedge clock);
        #1;
        chk("reset_tx", int'(uart_tx), 1);
        chk("reset_idle", int'(idle), 1);
        chk("reset_ovf", int'(overflow), 0);
        chk("reset_dcnt", int'(drop_count), 0);
        nreset = 1'b1;
        repeat (4) cyc(1'b0, 8'h00, 1'b0);

        // Single byte, exact line timing
        t0 = tx_hist.size();
        cyc(1'b1, 8'hA5, 1'b0);
        repeat (70) cyc(1'b0, 8'h00, 1'b0);
        ok = 1;
        for (int i = 3; i <= 8; i++) if (tx_hist[t0+i]) ok = 0;
        chk("s1_start_low", int'(ok), 1);
        ok = 1;
        for (int b = 0; b < 8; b++)
            for (int k = 0; k < DIV; k++)
                if (tx_hist[t0 + 9 + DIV*b + k] != a5[b]) ok = 0;
        chk("s1_data_bits", int'(ok), 1);
        ok = 1;
        for (int i = 57; i <= 62; i++) if (!tx_hist[t0+i]) ok = 0;
        chk("s1_stop_high", int'(ok), 1);
        chk("s1_idle_fall", int'({id_hist[t0], id_hist[t0+1]}), 2);
        chk("s1_idle_rise", int'({id_hist[t0+62], id_hist[t0+63]}), 1);
        drain("s1");

        // Back-to-back
        t0 = tx_hist.size();
        cyc(1'b1, 8'hFF, 1'b0);
        cyc(1'b1, 8'hD9, 1'b0);
        repeat (140) cyc(1'b0, 8'h00, 1'b0);
        f1 = find_fall(t0, t0 + 20);
        f2 = find_fall(f1 + 1, f1 + 100);
        chk("s2_first_start", f1 - t0, 3);
        chk("s2_start_spacing", f2 - f1, SLOT);
        drain("s2");

        // Overflow, then frame clear and drop-wins on the boundary
        for (int i = 0; i < 20; i++) cyc(1'b1, 8'($urandom), 1'b0);
        chk("s3_drop_count", int'(drop_count), 3);
        chk("s3_overflow", int'(overflow), 1);
        repeat (4) cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b0, 8'h00, 1'b0);
        chk("s4_clear", int'({overflow, drop_count}), 0);
        repeat (4) cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b1, 8'($urandom), 1'b0);
        chk("s4_drop_wins", int'({overflow, drop_count}), int'({1'b1, 8'd1}));
        drain("s3");

        // Reset during data bit 3 of 0x3C with 5 bytes still queued
        t0 = tx_hist.size();
        cyc(1'b1, 8'h3C, 1'b0);
        repeat (5) cyc(1'b1, 8'($urandom), 1'b0);
        while (tx_hist.size() < t0 + 29) cyc(1'b0, 8'h00, 1'b0);
        mid_reset();
        t1 = tx_hist.size();
        repeat (300) cyc(1'b0, 8'h00, 1'b0);
        ok = 1;
        for (int i = t1; i < tx_hist.size(); i++) if (!tx_hist[i] || !id_hist[i]) ok = 0;
        chk("s5_quiet_after_reset", int'(ok), 1);

        // Random traffic with random frame gaps
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) vs_cur = ~vs_cur;
            cyc($urandom_range(0, 29) == 0, 8'($urandom), vs_cur);
        end
        vs_cur = 0;
        drain("rnd");

        // Saturation with the FIFO held full
        repeat (2) cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 340; i++) cyc(1'b1, 8'($urandom), 1'b0);
        chk("s6_saturate", int'({overflow, drop_count}), int'({1'b1, 8'd255}));
        drain("s6");

        // Paced traffic across pointer wraps
        repeat (2) cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 40; i++) begin
            cyc(1'b1, 8'($urandom), 1'b0);
            repeat ($urandom_range(30, 70)) cyc(1'b0, 8'h00, 1'b0);
        end
        drain("wrap");
        chk("sb_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
